// File: rtl/uart_rx_if.sv
// Serial-receive bundle: line input plus received word and status strobes.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (output rx, input data, valid, frame_err, busy);
    modport slave  (input rx, output data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, LSB-first data, break hold-off.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int DATA_BITS      = 8
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int BW = $clog2(CLOCKS_PER_BIT);
    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] HALF = BW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST = BW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t               state, state_next;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [BW-1:0]        baud, baud_next;
    logic [CW-1:0]        bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [DATA_BITS-1:0] data_q, data_next;
    logic                 valid_q, valid_next;
    logic                 ferr_q, ferr_next;

    assign rx_s = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sync    <= 2'b11;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_next;
            sync    <= {sync[0], bus.rx};
            baud    <= baud_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
            data_q  <= data_next;
            valid_q <= valid_next;
            ferr_q  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = BW'(baud + 1'b1);
        bit_next   = bit_cnt;
        shift_next = shift;
        data_next  = data_q;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (baud == HALF) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud == LAST) begin
                    baud_next  = '0;
                    shift_next = {rx_s, shift[DATA_BITS-1:1]};
                    if (bit_cnt == LAST_BIT) state_next = STOP;
                    else                     bit_next   = CW'(bit_cnt + 1'b1);
                end
            end
            STOP: begin
                if (baud == LAST) begin
                    baud_next = '0;
                    if (rx_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // line must return high before a new start edge is considered
                baud_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: begin
                baud_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != IDLE);

    a_baud_range: assert property (@(posedge clk) disable iff (rst)
        32'(baud) < CLOCKS_PER_BIT);
    a_bit_range: assert property (@(posedge clk) disable iff (rst)
        32'(bit_cnt) < DATA_BITS);
    a_excl: assert property (@(posedge clk) disable iff (rst)
        !(valid_q && ferr_q));
    a_idle: assert property (@(posedge clk) disable iff (rst)
        !bus.busy |-> state == IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomized frame stimulus for uart_rx, checked against a frame-level expectation model.
module tb_uart_rx;
    localparam int CPB = 4;
    localparam int DB  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Observed behaviour, sampled on the falling edge
    logic [DB-1:0] got_q[$];
    int ferr_cnt = 0, both_cnt = 0, long_cnt = 0, data_bad = 0, busy_bad = 0, busy_hi = 0;
    int valid_cyc = 0;
    logic prev_valid = 1'b0, prev_ferr = 1'b0, rst_prev = 1'b1;
    logic [DB-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst && !rst_prev) begin
            if (bus.valid) begin
                got_q.push_back(bus.data);
                valid_cyc = cyc;
                if (bus.busy) busy_bad++;
            end
            if (bus.frame_err) ferr_cnt++;
            if (bus.valid && bus.frame_err) both_cnt++;
            if ((bus.valid && prev_valid) || (bus.frame_err && prev_ferr)) long_cnt++;
            if (!bus.valid && bus.data !== prev_data) data_bad++;
            if (bus.busy) busy_hi++;
        end
        prev_valid = bus.valid;
        prev_ferr  = bus.frame_err;
        prev_data  = bus.data;
        rst_prev   = rst;
    end

    // Expectation model: words that should be delivered, error count, last good word
    logic [DB-1:0] exp_q[$];
    int            exp_ferr = 0;
    logic [DB-1:0] exp_data = '0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.rx = b;
        tick(CPB);
    endtask

    task automatic tx_word(input logic [DB-1:0] w, input logic stop);
        if (stop) begin
            exp_q.push_back(w);
            exp_data = w;
        end else begin
            exp_ferr++;
        end
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(w[i]);
        send_bit(stop);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_word"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    int t0, bh, fe0;
    logic [DB-1:0] w;
    logic good;

    initial begin
        bus.rx = 1'b1;
        tick(3);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_data", bus.data, 0);
        rst = 1'b0;
        tick(4);

        // single frame plus start-to-valid latency
        t0 = cyc;
        tx_word(8'hA5, 1'b1);
        tick(4);
        compare_all("loopback");
        check("latency_ok", (valid_cyc - t0 >= 39) && (valid_cyc - t0 <= 41), 1);
        check("loop_busy", bus.busy, 0);
        check("loop_ferr", ferr_cnt, 0);

        // back-to-back frames with no idle gap
        tx_word(8'h00, 1'b1);
        tx_word(8'hFF, 1'b1);
        tx_word(8'h3C, 1'b1);
        tick(6);
        compare_all("b2b");

        // one-cycle low glitch
        bh = busy_hi;
        bus.rx = 1'b0;
        tick(1);
        bus.rx = 1'b1;
        tick(10);
        check("glitch_busy_seen", busy_hi > bh, 1);
        check("glitch_busy_end", bus.busy, 0);
        check("glitch_ferr", ferr_cnt, exp_ferr);
        compare_all("glitch");

        // stop bit low followed by a held break
        tx_word(8'h55, 1'b0);
        bus.rx = 1'b0;
        tick(20);
        check("brk_busy", bus.busy, 1);
        check("brk_ferr", ferr_cnt, exp_ferr);
        check("brk_data", bus.data, exp_data);
        bus.rx = 1'b1;
        tick(1);
        check("brk_busy_sync", bus.busy, 1);
        tick(3);
        check("brk_idle", bus.busy, 0);
        compare_all("brk");

        // reset during bit 3 of 0x81
        fe0 = ferr_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        bus.rx = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_data", bus.data, 0);
        check("mid_rst_valid", bus.valid, 0);
        check("mid_rst_ferr", bus.frame_err, 0);
        rst = 1'b0;
        bus.rx = 1'b1;
        exp_data = '0;
        tick(12);
        check("mid_rst_nopulse", ferr_cnt, fe0);
        compare_all("mid_rst_quiet");
        tx_word(8'h42, 1'b1);
        tick(4);
        compare_all("after_rst");
        check("after_rst_data", bus.data, 8'h42);

        // randomized traffic
        for (int k = 0; k < 30; k++) begin
            w    = DB'($urandom);
            good = ($urandom_range(0, 4) != 0);
            tx_word(w, good);
            if (!good) begin
                bus.rx = 1'b0;
                tick($urandom_range(0, 8));
                bus.rx = 1'b1;
                tick(3 + $urandom_range(0, 3));
            end else begin
                tick($urandom_range(0, 3));
            end
        end
        tick(8);
        compare_all("rand");
        check("rand_ferr", ferr_cnt, exp_ferr);
        check("rand_data", bus.data, exp_data);
        check("rand_idle", bus.busy, 0);

        check("never_both", both_cnt, 0);
        check("pulse_width", long_cnt, 0);
        check("data_stable", data_bad, 0);
        check("busy_at_valid", busy_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
